// File: rtl/enc_8_3_rr.sv
// Registered 8-to-3 round-robin encoder with a valid/ready output handshake.
// Optional multi_hot flag output enabled by defining ENC_MULTI_HOT_FLAG_EN.
module enc_8_3_rr #(
    parameter int N_IN  = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index,
    output logic [N_IN-1:0]  out_onehot,
    output logic             busy
`ifdef ENC_MULTI_HOT_FLAG_EN
    ,
    output logic             multi_hot
`endif
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } stateT;

    stateT            r_state;
    logic [IDX_W-1:0] r_rrPtr;
    logic [IDX_W-1:0] r_outIndex;
    logic [N_IN-1:0]  r_outOnehot;
    logic             r_outValid;
    logic             r_multiHot;

    logic             w_reqAny;
    logic             w_reqMulti;
    logic             w_handshake;
    logic [IDX_W-1:0] w_nextPtr;
    logic [IDX_W-1:0] w_selIdle;
    logic [IDX_W-1:0] w_selNext;

    // First set request bit scanning upward from ptr, wrapping modulo N_IN.
    function automatic logic [IDX_W-1:0] selFirst(input logic [N_IN-1:0] r,
                                                  input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] idx;
        logic             found;
        selFirst = ptr;
        found    = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            idx = ptr + IDX_W'(k);
            if (!found && r[idx]) begin
                selFirst = idx;
                found    = 1'b1;
            end
        end
    endfunction

    assign w_reqAny    = |req;
    assign w_reqMulti  = (req & (req - N_IN'(1))) != '0;
    assign w_handshake = r_outValid & out_ready;
    assign w_nextPtr   = r_outIndex + IDX_W'(1);
    assign w_selIdle   = selFirst(req, r_rrPtr);
    // Back-to-back selection must already see the pointer advanced past the grant.
    assign w_selNext   = selFirst(req, w_nextPtr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rrPtr     <= '0;
            r_outIndex  <= '0;
            r_outOnehot <= '0;
            r_outValid  <= 1'b0;
            r_multiHot  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_reqAny) begin
                        r_outIndex  <= w_selIdle;
                        r_outOnehot <= N_IN'(1) << w_selIdle;
                        r_outValid  <= 1'b1;
                        r_multiHot  <= w_reqMulti;
                        r_state     <= OFFER;
                    end
                end
                OFFER: begin
                    if (w_handshake) begin
                        r_rrPtr <= w_nextPtr;
                        if (w_reqAny) begin
                            r_outIndex  <= w_selNext;
                            r_outOnehot <= N_IN'(1) << w_selNext;
                            r_multiHot  <= w_reqMulti;
                        end else begin
                            r_outOnehot <= '0;
                            r_outValid  <= 1'b0;
                            r_multiHot  <= 1'b0;
                            r_state     <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid  = r_outValid;
    assign out_index  = r_outIndex;
    assign out_onehot = r_outOnehot;
    assign busy       = (r_state == OFFER);

`ifdef ENC_MULTI_HOT_FLAG_EN
    assign multi_hot  = r_multiHot;
`else
    logic w_unusedMulti;
    assign w_unusedMulti = r_multiHot;
`endif

endmodule

// File: tb/tb_enc_8_3_rr.sv
// Directed testbench for enc_8_3_rr with hand-computed expected values.
// Covers the multi_hot flag when ENC_MULTI_HOT_FLAG_EN is defined.
module tb_enc_8_3_rr;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_index;
    logic [7:0] out_onehot;
    logic       busy;
`ifdef ENC_MULTI_HOT_FLAG_EN
    logic       multi_hot;
`endif

    int compareCount;
    int mismatchCount;

    enc_8_3_rr dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_index  (out_index),
        .out_onehot (out_onehot),
        .busy       (busy)
`ifdef ENC_MULTI_HOT_FLAG_EN
        ,
        .multi_hot  (multi_hot)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] r, input logic rdy);
        req       = r;
        out_ready = rdy;
    endtask

    // Advance one active edge and settle just after it.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Expected indices for req=FF with continuous ready, starting at pointer 0.
    logic [2:0] ffSeq [9];

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        rst_n         = 1'b1;
        applyStimulus(8'h00, 1'b0);
        ffSeq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

        // Reset state
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_index", 32'(out_index), 32'd0);
        checkOutput("rst_onehot", 32'(out_onehot), 32'h00);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request, then drop
        applyStimulus(8'b0000_0100, 1'b1);
        stepCycle();
        checkOutput("single_valid", 32'(out_valid), 32'd1);
        checkOutput("single_index", 32'(out_index), 32'd2);
        checkOutput("single_onehot", 32'(out_onehot), 32'h04);
        checkOutput("single_busy", 32'(busy), 32'd1);
        applyStimulus(8'h00, 1'b1);
        stepCycle();
        checkOutput("drop_valid", 32'(out_valid), 32'd0);
        checkOutput("drop_onehot", 32'(out_onehot), 32'h00);
        checkOutput("drop_busy", 32'(busy), 32'd0);

        // All requesters with continuous ready: full rotation, no bubbles
        doReset();
        applyStimulus(8'hFF, 1'b1);
        for (int i = 0; i < 9; i++) begin
            stepCycle();
            checkOutput($sformatf("ff_valid%0d", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("ff_index%0d", i), 32'(out_index), 32'(ffSeq[i]));
            checkOutput($sformatf("ff_onehot%0d", i), 32'(out_onehot),
                        32'(8'h01 << ffSeq[i]));
        end
        applyStimulus(8'h00, 1'b1);
        stepCycle();
        checkOutput("ff_idle_valid", 32'(out_valid), 32'd0);

        // Stalled offer holds, then 7 and 0 alternate
        doReset();
        applyStimulus(8'b1000_0001, 1'b0);
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput($sformatf("stall_index%0d", i), 32'(out_index), 32'd0);
            checkOutput($sformatf("stall_valid%0d", i), 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        stepCycle();
        checkOutput("rr_index7", 32'(out_index), 32'd7);
        checkOutput("rr_onehot7", 32'(out_onehot), 32'h80);
        stepCycle();
        checkOutput("rr_index0", 32'(out_index), 32'd0);

        // Request withdrawn mid-offer does not alter the offer
        doReset();
        applyStimulus(8'h20, 1'b0);
        stepCycle();
        checkOutput("hold_index_first", 32'(out_index), 32'd5);
        applyStimulus(8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput($sformatf("hold_index%0d", i), 32'(out_index), 32'd5);
            checkOutput($sformatf("hold_valid%0d", i), 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        stepCycle();
        checkOutput("hold_end_valid", 32'(out_valid), 32'd0);
        checkOutput("hold_end_busy", 32'(busy), 32'd0);
        checkOutput("hold_end_onehot", 32'(out_onehot), 32'h00);

        // Ready while idle is ignored: pointer stays at 6 after the index-5 grant
        applyStimulus(8'h00, 1'b1);
        stepCycle();
        stepCycle();
        applyStimulus(8'h41, 1'b0);
        stepCycle();
        checkOutput("idle_ready_index", 32'(out_index), 32'd6);

        // Asynchronous reset drops a pending offer without a clock edge
        doReset();
        applyStimulus(8'h40, 1'b0);
        stepCycle();
        checkOutput("pre_rst_index", 32'(out_index), 32'd6);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_valid", 32'(out_valid), 32'd0);
        checkOutput("async_index", 32'(out_index), 32'd0);
        checkOutput("async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'hFF, 1'b0);
        stepCycle();
        checkOutput("post_rst_index", 32'(out_index), 32'd0);
        checkOutput("post_rst_valid", 32'(out_valid), 32'd1);

`ifdef ENC_MULTI_HOT_FLAG_EN
        doReset();
        applyStimulus(8'h10, 1'b1);
        stepCycle();
        checkOutput("mh_single_index", 32'(out_index), 32'd4);
        checkOutput("mh_single_flag", 32'(multi_hot), 32'd0);
        applyStimulus(8'h00, 1'b1);
        stepCycle();
        doReset();
        applyStimulus(8'h30, 1'b0);
        stepCycle();
        checkOutput("mh_multi_index", 32'(out_index), 32'd4);
        checkOutput("mh_multi_flag", 32'(multi_hot), 32'd1);
        applyStimulus(8'h00, 1'b1);
        stepCycle();
        checkOutput("mh_clear_flag", 32'(multi_hot), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/enc_8_3_rr.md
Name: enc_8_3_rr

Overview:
- Sequential 8-to-3 encoder with round-robin arbitration.
- Converts an 8-bit request vector into a registered 3-bit index plus a one-hot echo.
- Delivers the result over a valid/ready handshake.
- Inverse of the one-hot/select decoder on the CPU select paths: it produces the selection index that the decoder consumes.

Parameters:
- N_IN, 8, number of request lines; only 8 is supported.
- IDX_W, 3, index width; must equal log2(N_IN).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  level-sensitive request lines; bit i requests index i.
- out_ready  input  1  consumer accepts out_index this cycle.
- out_valid  output  1  out_index / out_onehot hold a valid selection.
- out_index  output  3  binary index of the granted request.
- out_onehot  output  8  one-hot form of out_index (1 << out_index); 0 when out_valid=0.
- busy  output  1  high while in state OFFER.

Behaviour:
- One clock. Reset is asynchronous and active-low (rst_n); all state is cleared on assertion, independent of clk.
- Reset values: out_valid=0, out_index=0, out_onehot=0, busy=0, state=IDLE, rr_ptr=0.
- rr_ptr (3 bits) is the highest-priority index for the next selection.
- Selection function sel(req, rr_ptr): first set bit scanning rr_ptr, rr_ptr+1, ..., 7, 0, ..., rr_ptr-1 (mod 8). Purely combinational.
- State IDLE:
  - req==0: stay in IDLE, out_valid=0.
  - req!=0: on the next edge, register out_index=sel, out_onehot=1<<sel, out_valid=1, go to OFFER.
  - Latency from req to out_valid: 1 cycle.
- State OFFER:
  - out_index and out_onehot hold stable until handshake (out_valid & out_ready).
  - Dropping req mid-offer does not retract or alter the offer.
  - On handshake, rr_ptr <= out_index+1 (7 wraps to 0).
  - Handshake with req!=0 (current req, evaluated against the updated pointer, i.e. out_index+1): back-to-back. Load the new selection the same edge; out_valid stays 1; remain in OFFER; no bubble.
  - Handshake with req==0: out_valid=0, out_onehot=0, go to IDLE.
- out_ready while out_valid=0 is ignored; rr_ptr does not change.
- Any single requester is granted again only after every other continuously asserted requester is granted once (fairness bound: 8 handshakes).
- rst_n asserted mid-offer: the offer is dropped immediately and rr_ptr returns to 0. After release, the first selection follows normal IDLE rules.
- rst_n deassertion is expected synchronised externally; the block adds no synchroniser.

Optional Feature:
- Macro ENC_MULTI_HOT_FLAG_EN.
- When defined:
  - Adds output port multi_hot (1 bit, reset 0).
  - multi_hot is registered alongside out_index on every new selection: 1 if the sampled req had more than one bit set, else 0.
  - Holds for the life of the offer; clears with out_valid.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then req=8'b0000_0100, out_ready=1 → next cycle out_valid=1, out_index=2, out_onehot=8'h04; following cycle, with req dropped, out_valid=0.
- req=8'hFF held, out_ready=1 continuously → out_index sequence 0,1,2,3,4,5,6,7,0 on consecutive cycles; out_valid stays 1 throughout.
- req=8'b1000_0001, out_ready=0 for 5 cycles, then 1 → out_index=0 stable for all 5 cycles; after handshake the next index is 7, then 0.
- Offer out_index=5 pending, req drops to 0 before out_ready → out_index stays 5 until out_ready=1; then out_valid=0, busy=0, state IDLE.
- rst_n pulled low while out_valid=1, out_index=6 → out_valid=0 and out_index=0 without waiting for a clock edge; after release with req=8'hFF, first grant is index 0.
- ENC_MULTI_HOT_FLAG_EN defined: req=8'h10 → multi_hot=0; req=8'h30 → multi_hot=1 with out_index=4.
